// File: rtl/mem_pool_pkg.sv
// Shared definitions for the image memory pool: requester indices, owner tag
// type and the round-robin pointer encoding.
package mem_pool_pkg;

    localparam int unsigned REQ_NUM  = 3;
    localparam int unsigned REQ_CONV = 0;
    localparam int unsigned REQ_MISC = 1;
    localparam int unsigned REQ_SAVE = 2;

    // One-hot owner tag, bit index = requester index; zero means no owner.
    typedef logic [REQ_NUM-1:0] req_tag_t;

    typedef enum logic [1:0] {
        PTR_CONV = 2'd0,
        PTR_MISC = 2'd1,
        PTR_SAVE = 2'd2
    } rr_ptr_e;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way grant logic for grp_read_sched. GRP_READ_SCHED_RR_EN selects
// round-robin (conv->misc->save->conv); otherwise fixed priority conv > misc > save.
module rr_arbiter3
    import mem_pool_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [2:0]     req,
    input  logic           advance,
    output logic [2:0]     grant
);

`ifdef GRP_READ_SCHED_RR_EN
    rr_ptr_e ptr_q, ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= PTR_CONV;
        else        ptr_q <= ptr_d;
    end

    // Pointer moves to the requester following the winner.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            if (grant[REQ_CONV])      ptr_d = PTR_MISC;
            else if (grant[REQ_MISC]) ptr_d = PTR_SAVE;
            else if (grant[REQ_SAVE]) ptr_d = PTR_CONV;
        end
    end

    always_comb begin
        grant = '0;
        unique case (ptr_q)
            PTR_CONV: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
            PTR_MISC: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            PTR_SAVE: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: grant = '0;
        endcase
    end
`else
    logic unused_arb_inputs;
    assign unused_arb_inputs = ^{clk, rst_n, advance};

    always_comb begin
        grant = '0;
        if (req[0])      grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
    end
`endif

endmodule

// File: rtl/grp_read_sched.sv
// Per-group read scheduler: arbitrates conv/misc/save onto one bank read port,
// tags each issue through the RAM latency and returns data to its owner.
// Arbitration mode is selected by GRP_READ_SCHED_RR_EN (see rr_arbiter3).
module grp_read_sched
    import mem_pool_pkg::*;
#(
    parameter int unsigned ROW_PARA        = 4,
    parameter int unsigned CHL_PARA        = 8,
    parameter int unsigned BANK_ADDR_WIDTH = 12,
    parameter int unsigned BANK_UNIT_WIDTH = 8,
    parameter int unsigned RAM_LAT         = 2
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          conv_read_valid_i,
    input  logic [ROW_PARA-1:0]                           conv_read_bank_en_i,
    input  logic [ROW_PARA*BANK_ADDR_WIDTH-1:0]           conv_read_addr_i,
    output logic                                          conv_read_ready_o,
    output logic [ROW_PARA*BANK_UNIT_WIDTH*CHL_PARA-1:0]  conv_read_data_o,
    output logic                                          conv_read_data_valid_o,
    input  logic                                          misc_read_valid_i,
    input  logic [ROW_PARA-1:0]                           misc_read_bank_en_i,
    input  logic [ROW_PARA*BANK_ADDR_WIDTH-1:0]           misc_read_addr_i,
    output logic                                          misc_read_ready_o,
    output logic [ROW_PARA*BANK_UNIT_WIDTH*CHL_PARA-1:0]  misc_read_data_o,
    output logic                                          misc_read_data_valid_o,
    input  logic                                          save_read_valid_i,
    input  logic [ROW_PARA-1:0]                           save_read_bank_en_i,
    input  logic [ROW_PARA*BANK_ADDR_WIDTH-1:0]           save_read_addr_i,
    output logic                                          save_read_ready_o,
    output logic [ROW_PARA*BANK_UNIT_WIDTH*CHL_PARA-1:0]  save_read_data_o,
    output logic                                          save_read_data_valid_o,
    output logic [ROW_PARA-1:0]                           ram_read_bank_en_o,
    output logic [ROW_PARA*BANK_ADDR_WIDTH-1:0]           ram_read_addr_o,
    input  logic [ROW_PARA*BANK_UNIT_WIDTH*CHL_PARA-1:0]  ram_read_data_i
);

    localparam int unsigned DW = ROW_PARA * BANK_UNIT_WIDTH * CHL_PARA;
    localparam int unsigned AW = ROW_PARA * BANK_ADDR_WIDTH;

    logic [2:0]          req;
    logic [2:0]          grant;
    logic [ROW_PARA-1:0] issue_en_d, issue_en_q;
    logic [AW-1:0]       issue_addr_d, issue_addr_q;
    req_tag_t            tag_q [RAM_LAT+1];
    req_tag_t            ret_valid_q;
    logic [DW-1:0]       ret_data_q [REQ_NUM];

    assign req = {save_read_valid_i, misc_read_valid_i, conv_read_valid_i};

    rr_arbiter3 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (|grant),
        .grant   (grant)
    );

    assign conv_read_ready_o = grant[REQ_CONV];
    assign misc_read_ready_o = grant[REQ_MISC];
    assign save_read_ready_o = grant[REQ_SAVE];

    always_comb begin
        issue_en_d   = '0;
        issue_addr_d = issue_addr_q;
        if (grant[REQ_CONV]) begin
            issue_en_d   = conv_read_bank_en_i;
            issue_addr_d = conv_read_addr_i;
        end else if (grant[REQ_MISC]) begin
            issue_en_d   = misc_read_bank_en_i;
            issue_addr_d = misc_read_addr_i;
        end else if (grant[REQ_SAVE]) begin
            issue_en_d   = save_read_bank_en_i;
            issue_addr_d = save_read_addr_i;
        end
    end

    // tag_q[0] rides with the issue register; tag_q[RAM_LAT] lines up with RAM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_en_q   <= '0;
            issue_addr_q <= '0;
            for (int unsigned i = 0; i <= RAM_LAT; i++) tag_q[i] <= '0;
        end else begin
            issue_en_q   <= issue_en_d;
            issue_addr_q <= issue_addr_d;
            tag_q[0]     <= grant;
            for (int unsigned i = 1; i <= RAM_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_valid_q <= '0;
            for (int unsigned r = 0; r < REQ_NUM; r++) ret_data_q[r] <= '0;
        end else begin
            ret_valid_q <= tag_q[RAM_LAT];
            for (int unsigned r = 0; r < REQ_NUM; r++) begin
                if (tag_q[RAM_LAT][r]) ret_data_q[r] <= ram_read_data_i;
            end
        end
    end

    assign ram_read_bank_en_o     = issue_en_q;
    assign ram_read_addr_o        = issue_addr_q;
    assign conv_read_data_o       = ret_data_q[REQ_CONV];
    assign misc_read_data_o       = ret_data_q[REQ_MISC];
    assign save_read_data_o       = ret_data_q[REQ_SAVE];
    assign conv_read_data_valid_o = ret_valid_q[REQ_CONV];
    assign misc_read_data_valid_o = ret_valid_q[REQ_MISC];
    assign save_read_data_valid_o = ret_valid_q[REQ_SAVE];

endmodule

// File: tb/tb_grp_read_sched.sv
// Directed bench for grp_read_sched; expected grant orders depend on
// whether GRP_READ_SCHED_RR_EN is defined.
module tb_grp_read_sched;
    import mem_pool_pkg::*;

    localparam int unsigned ROW_PARA = 4;
    localparam int unsigned CHL_PARA = 8;
    localparam int unsigned BAW      = 12;
    localparam int unsigned BUW      = 8;
    localparam int unsigned RAM_LAT  = 2;
    localparam int unsigned DW       = ROW_PARA * BUW * CHL_PARA;
    localparam int unsigned AW       = ROW_PARA * BAW;

    typedef struct packed {
        logic [ROW_PARA-1:0] en;
        logic [AW-1:0]       addr;
    } rd_req_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [2:0]          valid = '0;
    logic [ROW_PARA-1:0] en_in   [3];
    logic [AW-1:0]       addr_in [3];
    wire  [2:0]          rdy;
    wire  [2:0]          dv;
    wire  [DW-1:0]       data_w  [3];
    wire  [ROW_PARA-1:0] ram_en;
    wire  [AW-1:0]       ram_addr;
    logic [DW-1:0]       ram_data;
    logic [AW-1:0]       hist    [RAM_LAT];

    int n_cmp = 0;
    int n_err = 0;

    rd_req_t    pend [3][$];
    logic [2:0] exp_g [$];

    always #5 clk = ~clk;

    grp_read_sched #(
        .ROW_PARA        (ROW_PARA),
        .CHL_PARA        (CHL_PARA),
        .BANK_ADDR_WIDTH (BAW),
        .BANK_UNIT_WIDTH (BUW),
        .RAM_LAT         (RAM_LAT)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .conv_read_valid_i      (valid[0]),
        .conv_read_bank_en_i    (en_in[0]),
        .conv_read_addr_i       (addr_in[0]),
        .conv_read_ready_o      (rdy[0]),
        .conv_read_data_o       (data_w[0]),
        .conv_read_data_valid_o (dv[0]),
        .misc_read_valid_i      (valid[1]),
        .misc_read_bank_en_i    (en_in[1]),
        .misc_read_addr_i       (addr_in[1]),
        .misc_read_ready_o      (rdy[1]),
        .misc_read_data_o       (data_w[1]),
        .misc_read_data_valid_o (dv[1]),
        .save_read_valid_i      (valid[2]),
        .save_read_bank_en_i    (en_in[2]),
        .save_read_addr_i       (addr_in[2]),
        .save_read_ready_o      (rdy[2]),
        .save_read_data_o       (data_w[2]),
        .save_read_data_valid_o (dv[2]),
        .ram_read_bank_en_o     (ram_en),
        .ram_read_addr_o        (ram_addr),
        .ram_read_data_i        (ram_data)
    );

    // Bank model: data is a fixed function of the address issued RAM_LAT cycles ago.
    function automatic logic [DW-1:0] ram_model(input logic [AW-1:0] a);
        return {4{a, 16'hC0DE}};
    endfunction

    always @(posedge clk) begin
        hist[0] <= ram_addr;
        for (int i = 1; i < RAM_LAT; i++) hist[i] <= hist[i-1];
    end
    assign ram_data = ram_model(hist[RAM_LAT-1]);

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rd_req_t mk(input int r, input int k);
        rd_req_t q;
        logic [ROW_PARA-1:0] kk;
        kk = k[ROW_PARA-1:0];
        q.en = ~kk;
        for (int b = 0; b < ROW_PARA; b++) q.addr[b*BAW +: BAW] = BAW'(r * 256 + k * 16 + b);
        return q;
    endfunction

    task automatic clear_pend();
        for (int r = 0; r < 3; r++) pend[r].delete();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = '0;
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // Runs the pending requests cycle by cycle against the expected grant table.
    task automatic run_seq(input string name, input int drive_cycles);
        logic [2:0] iss_own [$];
        rd_req_t    iss_req [$];
        logic [2:0] own;
        logic [2:0] eg;
        rd_req_t    rq;
        int         total;
        total = drive_cycles + RAM_LAT + 4;
        for (int c = 0; c < total; c++) begin
            if (c >= 1) begin
                own = iss_own[c-1];
                rq  = iss_req[c-1];
                check($sformatf("%s.ram_en c%0d", name, c), DW'(ram_en), (own != 0) ? DW'(rq.en) : '0);
                if (own != 0) check($sformatf("%s.ram_addr c%0d", name, c), DW'(ram_addr), DW'(rq.addr));
            end
            if (c >= 2 + RAM_LAT) begin
                own = iss_own[c-2-RAM_LAT];
                rq  = iss_req[c-2-RAM_LAT];
                check($sformatf("%s.dv c%0d", name, c), DW'(dv), DW'(own));
                for (int r = 0; r < 3; r++) begin
                    if (own[r]) check($sformatf("%s.data%0d c%0d", name, r, c), data_w[r], ram_model(rq.addr));
                end
            end else begin
                check($sformatf("%s.dv c%0d", name, c), DW'(dv), '0);
            end
            for (int r = 0; r < 3; r++) begin
                if (c < drive_cycles && pend[r].size() > 0) begin
                    valid[r]   = 1'b1;
                    en_in[r]   = pend[r][0].en;
                    addr_in[r] = pend[r][0].addr;
                end else begin
                    valid[r] = 1'b0;
                end
            end
            #1;
            eg = (c < exp_g.size()) ? exp_g[c] : 3'b000;
            check($sformatf("%s.ready c%0d", name, c), DW'(rdy), DW'(eg));
            rq = '0;
            for (int r = 0; r < 3; r++) begin
                if (eg[r] && pend[r].size() > 0) rq = pend[r].pop_front();
            end
            iss_own.push_back(eg);
            iss_req.push_back(rq);
            cycle();
        end
        valid = '0;
        clear_pend();
    endtask

    initial begin
        for (int r = 0; r < 3; r++) begin
            en_in[r]   = '0;
            addr_in[r] = '0;
        end
        cycle();
        cycle();
        check("rst.ready", DW'(rdy), '0);
        check("rst.dv", DW'(dv), '0);
        check("rst.ram_en", DW'(ram_en), '0);
        check("rst.ram_addr", DW'(ram_addr), '0);
        for (int r = 0; r < 3; r++) check($sformatf("rst.data%0d", r), data_w[r], '0);
        rst_n = 1'b1;
        cycle();

        // Single conv read: bank0=0x010, bank2=0x020, mask 0101
        pend[0].push_back(rd_req_t'{en: 4'b0101, addr: 48'h000_020_000_010});
        exp_g = '{3'b001};
        run_seq("single", 1);

        // All three valid for six cycles
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 6; k++) pend[r].push_back(mk(r, k));
`ifdef GRP_READ_SCHED_RR_EN
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        run_seq("all3", 6);

        // misc with empty bank mask still returns a pulse
        pend[1].push_back(rd_req_t'{en: 4'b0000, addr: 48'h123_456_789_abc});
        exp_g = '{3'b001 << 1};
        run_seq("misc_en0", 1);

        // misc held while conv is served; nothing lost or duplicated
        do_reset();
        for (int k = 0; k < 3; k++) pend[0].push_back(mk(0, k + 8));
        pend[1].push_back(mk(1, 9));
`ifdef GRP_READ_SCHED_RR_EN
        exp_g = '{3'b001, 3'b010, 3'b001, 3'b001};
`else
        exp_g = '{3'b001, 3'b001, 3'b001, 3'b010};
`endif
        run_seq("hold", 4);

        // Reset one cycle after a save accept drops the in-flight return
        valid[2]   = 1'b1;
        en_in[2]   = 4'b1111;
        addr_in[2] = 48'hfed_cba_987_654;
        #1;
        check("rstmid.ready", DW'(rdy), DW'(3'b100));
        cycle();
        valid = '0;
        rst_n = 1'b0;
        #1;
        check("rstmid.ram_en", DW'(ram_en), '0);
        check("rstmid.ram_addr", DW'(ram_addr), '0);
        check("rstmid.dv", DW'(dv), '0);
        for (int r = 0; r < 3; r++) check($sformatf("rstmid.data%0d", r), data_w[r], '0);
        cycle();
        rst_n = 1'b1;
        for (int c = 0; c < RAM_LAT + 4; c++) begin
            check($sformatf("rstmid.dv_after c%0d", c), DW'(dv), '0);
            cycle();
        end

        // Pointer returns to conv on reset
        pend[0].push_back(mk(0, 3));
        exp_g = '{3'b001};
        run_seq("ptr_pre", 1);
        do_reset();
        for (int r = 0; r < 3; r++) pend[r].push_back(mk(r, 4));
        exp_g = '{3'b001};
        run_seq("ptr_reset", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
